chassis_decode: RTL and testbench
=================================

CHASSIS_DECODE -- requirements
Module: chassis_decode

Interface
REQ-001 SHALL have parameter DIRECTION_WIDTH, default 3: width of the recovered direction code.
REQ-002 SHALL have parameter STABLE_CYCLES, default 4, legal range 2..15: consecutive identical samples required before a pattern is accepted.
REQ-003 SHALL have port clk, input, 1 bit: the only clock; all logic updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port dir_in, input, 8 bits: H-bridge drive pattern, pairs {bit2k+1, bit2k} for wheel k = 0..3 (bit2k = forward leg).
REQ-006 SHALL have port out_ready, input, 1 bit: consumer accepts the current event when high together with dir_valid.
REQ-007 SHALL have port direction, output, DIRECTION_WIDTH bits: decoded code of the pending event.
REQ-008 SHALL have port dir_valid, output, 1 bit: an event is pending.
REQ-009 SHALL have port fault, output, 1 bit: sticky shoot-through flag.
REQ-010 SHALL have port overrun, output, 1 bit: sticky flag, set when an unaccepted event is overwritten.
REQ-011 SHALL have port event_count, output, 8 bits: count of events generated since reset.

Function
REQ-012 SHALL register dir_in into dir_q on every edge; all decoding SHALL use dir_q only.
REQ-013 SHALL hold a stability counter:
  - cleared to 0 when dir_q differs from the previous dir_q;
  - otherwise incremented, saturating at STABLE_CYCLES-1.
REQ-014 SHALL decode stable patterns as follows:
  - 0x00 -> 0 (stop)
  - 0x55 -> 1 (forward)
  - 0xAA -> 2 (backward)
  - 0x5A -> 3 (left)
  - 0xA5 -> 4 (right)
  - any pattern with both bits of any pair high -> 7 (shoot-through)
  - every other pattern -> 5 (unknown)
REQ-015 SHALL run a two-state FSM:
  - TRACK: waits for stability.
  - HOLD: pattern accepted and reported.
  - TRACK -> HOLD when the counter reaches STABLE_CYCLES-1 and dir_q differs from last_pattern.
  - TRACK -> HOLD without an event when the counter reaches STABLE_CYCLES-1 and dir_q equals last_pattern.
  - HOLD -> TRACK on any change of dir_q.
REQ-016 On the TRACK->HOLD transition with an event, on the same edge, the block SHALL:
  - load direction with the decoded code;
  - set dir_valid;
  - store dir_q into last_pattern;
  - increment event_count, which wraps 255 -> 0.
REQ-017 Latency: a pattern first captured into dir_q at edge E SHALL raise dir_valid at edge E+STABLE_CYCLES-1, which is STABLE_CYCLES edges after it first appears at dir_in.
REQ-018 SHALL clear dir_valid on the edge where dir_valid and out_ready are both high; direction SHALL then hold its value.
REQ-019 If a new event occurs on the same edge that an old event is accepted, the new event SHALL load and dir_valid SHALL stay high; overrun SHALL NOT set.
REQ-020 If a new event occurs while dir_valid is high and out_ready is low, the new event SHALL overwrite direction (latest wins) and overrun SHALL set.
REQ-021 A pattern shorter than STABLE_CYCLES samples SHALL produce no event and SHALL NOT change last_pattern.
REQ-022 fault SHALL set on the edge after any pair in dir_q has both bits high, without waiting for stability.
REQ-023 Once set, fault and overrun SHALL hold until reset.

Reset
REQ-024 On any edge with rst high, the block SHALL set:
  - dir_q = 0x00, last_pattern = 0x00, counter = 0, FSM = TRACK;
  - direction = 0, dir_valid = 0, fault = 0, overrun = 0, event_count = 0.
REQ-025 Reset asserted mid-event SHALL discard any pending event; a stop pattern after reset SHALL NOT generate an event.
REQ-026 The first edge after rst deasserts SHALL sample dir_in normally.

Verification (STABLE_CYCLES=4)
REQ-027 Reset, then dir_in=0x55 held with out_ready=1 -> dir_valid high for 1 cycle 4 edges after dir_in changes, direction=1, event_count=1.
REQ-028 dir_in=0x5A for 3 cycles, then back to 0x55 -> no event; event_count unchanged; last_pattern remains 0x55.
REQ-029 out_ready=0; apply 0xAA stable, then 0xA5 stable -> direction=4, dir_valid=1, overrun=1, event_count=2.
REQ-030 dir_in=0x03 for 1 cycle -> fault=1 from the 2nd edge onward and sticky; no event is generated.
REQ-031 Apply 0x81 stable -> direction=5; then 0x00 stable -> direction=0; then 0x00 held further -> no additional event.
REQ-032 With dir_valid=1 and 0x55 pending, assert rst for 1 cycle -> all outputs 0; holding 0x00 afterwards produces no event.

Source files
------------

// File: rtl/chassis_decode.sv
// Decodes an 8-bit H-bridge drive pattern into a direction event once the pattern has been stable,
// with a ready/valid handoff, sticky shoot-through and overrun flags, and a wrapping event counter.
module chassis_decode #(
    parameter int DIRECTION_WIDTH = 3,
    parameter int STABLE_CYCLES   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 dir_in,
    input  logic                       out_ready,
    output logic [DIRECTION_WIDTH-1:0] direction,
    output logic                       dir_valid,
    output logic                       fault,
    output logic                       overrun,
    output logic [7:0]                 event_count
);

    localparam logic [3:0] C_MAX = 4'(STABLE_CYCLES - 1);

    typedef enum logic {
        S_TRACK = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [7:0]                 r_dir_q;
    logic [7:0]                 r_last;
    logic [3:0]                 r_cnt;
    logic [3:0]                 w_cnt_nxt;
    logic                       w_same;
    logic                       w_event;
    logic                       w_shoot;
    logic [DIRECTION_WIDTH-1:0] r_direction;
    logic                       r_valid;
    logic                       r_fault;
    logic                       r_overrun;
    logic [7:0]                 r_evcnt;

    function automatic logic has_shoot(input logic [7:0] p);
        has_shoot = (p[1] & p[0]) | (p[3] & p[2]) | (p[5] & p[4]) | (p[7] & p[6]);
    endfunction

    function automatic logic [2:0] decode_dir(input logic [7:0] p);
        if (has_shoot(p)) begin
            decode_dir = 3'd7;
        end else begin
            case (p)
                8'h00:   decode_dir = 3'd0;
                8'h55:   decode_dir = 3'd1;
                8'hAA:   decode_dir = 3'd2;
                8'h5A:   decode_dir = 3'd3;
                8'hA5:   decode_dir = 3'd4;
                default: decode_dir = 3'd5;
            endcase
        end
    endfunction

    // The incoming sample is compared against dir_q so the counter reaches its limit on the
    // same edge that completes the required run of identical samples.
    assign w_same  = (dir_in == r_dir_q);
    assign w_shoot = has_shoot(r_dir_q);

    // Stability counter next value, saturating at STABLE_CYCLES-1.
    always_comb begin
        w_cnt_nxt = 4'd0;
        if (!w_same) begin
            w_cnt_nxt = 4'd0;
        end else if (r_cnt == C_MAX) begin
            w_cnt_nxt = r_cnt;
        end else begin
            w_cnt_nxt = r_cnt + 4'd1;
        end
    end

    // Next-state and event generation for the TRACK/HOLD FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_event     = 1'b0;
        case (r_state)
            S_TRACK: begin
                if (w_cnt_nxt == C_MAX) begin
                    w_state_nxt = S_HOLD;
                    w_event     = (r_dir_q != r_last);
                end else begin
                    w_state_nxt = S_TRACK;
                end
            end
            S_HOLD: begin
                if (!w_same) begin
                    w_state_nxt = S_TRACK;
                end else begin
                    w_state_nxt = S_HOLD;
                end
            end
            default: w_state_nxt = S_TRACK;
        endcase
    end

    // Input capture, stability counter and FSM state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dir_q <= 8'h00;
            r_cnt   <= 4'd0;
            r_state <= S_TRACK;
        end else begin
            r_dir_q <= dir_in;
            r_cnt   <= w_cnt_nxt;
            r_state <= w_state_nxt;
        end
    end

    // Event register, handshake and sticky status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last      <= 8'h00;
            r_direction <= '0;
            r_valid     <= 1'b0;
            r_fault     <= 1'b0;
            r_overrun   <= 1'b0;
            r_evcnt     <= 8'd0;
        end else begin
            if (w_event) begin
                r_last      <= r_dir_q;
                r_direction <= DIRECTION_WIDTH'(decode_dir(r_dir_q));
                r_valid     <= 1'b1;
                r_evcnt     <= r_evcnt + 8'd1;
                if (r_valid && !out_ready) begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && out_ready) begin
                r_valid <= 1'b0;
            end
            if (w_shoot) begin
                r_fault <= 1'b1;
            end
        end
    end

    assign direction   = r_direction;
    assign dir_valid   = r_valid;
    assign fault       = r_fault;
    assign overrun     = r_overrun;
    assign event_count = r_evcnt;

endmodule

// File: tb/tb_chassis_decode.sv
// Table-driven directed bench for chassis_decode (STABLE_CYCLES=4), plus hand-written
// sequences for simultaneous accept/new event, shoot-through decode and counter wrap.
module tb_chassis_decode;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] dir_in;
    logic       out_ready;
    logic [2:0] direction;
    logic       dir_valid;
    logic       fault;
    logic       overrun;
    logic [7:0] event_count;

    int errors = 0;
    int checks = 0;

    chassis_decode #(.DIRECTION_WIDTH(3), .STABLE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .dir_in(dir_in), .out_ready(out_ready),
        .direction(direction), .dir_valid(dir_valid), .fault(fault),
        .overrun(overrun), .event_count(event_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] din;
        logic       rdy;
        logic [2:0] e_dir;
        logic       e_v;
        logic       e_f;
        logic       e_o;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] d, input logic v,
                             input logic f, input logic o, input logic [7:0] c);
        check({tag, ".direction"}, {5'd0, direction}, {5'd0, d});
        check({tag, ".dir_valid"}, {7'd0, dir_valid}, {7'd0, v});
        check({tag, ".fault"}, {7'd0, fault}, {7'd0, f});
        check({tag, ".overrun"}, {7'd0, overrun}, {7'd0, o});
        check({tag, ".event_count"}, event_count, c);
    endtask

    // Apply inputs, let one rising edge pass, return 1 time unit later.
    task automatic drive(input logic r, input logic [7:0] d, input logic rdy);
        rst       = r;
        dir_in    = d;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_n(input logic [7:0] d, input logic rdy, input int n);
        for (int k = 0; k < n; k++) drive(1'b0, d, rdy);
    endtask

    task automatic add(input logic r, input logic [7:0] d, input logic rdy, input logic [2:0] ed,
                       input logic ev, input logic ef, input logic eo, input logic [7:0] ec);
        vec_t t;
        t = '{r, d, rdy, ed, ev, ef, eo, ec};
        vq.push_back(t);
    endtask

    initial begin
        rst = 1'b1; dir_in = 8'h00; out_ready = 1'b0;

        // reset, 0x55 forward event on the 4th edge, accepted next edge
        add(1, 8'h00, 1, 3'd0, 0, 0, 0, 8'd0);
        add(0, 8'h55, 1, 3'd0, 0, 0, 0, 8'd0);
        add(0, 8'h55, 1, 3'd0, 0, 0, 0, 8'd0);
        add(0, 8'h55, 1, 3'd0, 0, 0, 0, 8'd0);
        add(0, 8'h55, 1, 3'd1, 1, 0, 0, 8'd1);
        add(0, 8'h55, 1, 3'd1, 0, 0, 0, 8'd1);
        // 3-sample 0x5A glitch then back to 0x55: no event
        add(0, 8'h5A, 1, 3'd1, 0, 0, 0, 8'd1);
        add(0, 8'h5A, 1, 3'd1, 0, 0, 0, 8'd1);
        add(0, 8'h5A, 1, 3'd1, 0, 0, 0, 8'd1);
        for (int k = 0; k < 5; k++) add(0, 8'h55, 1, 3'd1, 0, 0, 0, 8'd1);
        // reset, then 0xAA and 0xA5 unaccepted: overrun, latest wins
        add(1, 8'h00, 0, 3'd0, 0, 0, 0, 8'd0);
        for (int k = 0; k < 3; k++) add(0, 8'hAA, 0, 3'd0, 0, 0, 0, 8'd0);
        add(0, 8'hAA, 0, 3'd2, 1, 0, 0, 8'd1);
        for (int k = 0; k < 3; k++) add(0, 8'hA5, 0, 3'd2, 1, 0, 0, 8'd1);
        add(0, 8'hA5, 0, 3'd4, 1, 0, 1, 8'd2);
        add(0, 8'hA5, 1, 3'd4, 0, 0, 1, 8'd2);
        // single-cycle 0x03: fault on the 2nd edge, sticky, no event
        add(0, 8'h03, 1, 3'd4, 0, 0, 1, 8'd2);
        for (int k = 0; k < 4; k++) add(0, 8'hA5, 1, 3'd4, 0, 1, 1, 8'd2);
        // 0x81 unknown, then 0x00 stop, then 0x00 held with no new event
        for (int k = 0; k < 3; k++) add(0, 8'h81, 1, 3'd4, 0, 1, 1, 8'd2);
        add(0, 8'h81, 1, 3'd5, 1, 1, 1, 8'd3);
        for (int k = 0; k < 3; k++) add(0, 8'h00, 1, 3'd5, 0, 1, 1, 8'd3);
        add(0, 8'h00, 1, 3'd0, 1, 1, 1, 8'd4);
        for (int k = 0; k < 3; k++) add(0, 8'h00, 1, 3'd0, 0, 1, 1, 8'd4);
        // 0x55 pending, then reset mid-event; 0x00 afterwards yields nothing
        for (int k = 0; k < 3; k++) add(0, 8'h55, 0, 3'd0, 0, 1, 1, 8'd4);
        add(0, 8'h55, 0, 3'd1, 1, 1, 1, 8'd5);
        add(1, 8'h55, 0, 3'd0, 0, 0, 0, 8'd0);
        for (int k = 0; k < 6; k++) add(0, 8'h00, 1, 3'd0, 0, 0, 0, 8'd0);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst, vq[i].din, vq[i].rdy);
            check_all($sformatf("vec%0d", i), vq[i].e_dir, vq[i].e_v, vq[i].e_f, vq[i].e_o, vq[i].e_cnt);
        end

        // New event on the same edge the old one is accepted: loads, valid stays, no overrun
        drive(1'b1, 8'h00, 1'b0);
        drive_n(8'h55, 1'b0, 4);
        check_all("seq_first", 3'd1, 1'b1, 1'b0, 1'b0, 8'd1);
        drive_n(8'hAA, 1'b0, 3);
        drive(1'b0, 8'hAA, 1'b1);
        check_all("seq_accept_and_new", 3'd2, 1'b1, 1'b0, 1'b0, 8'd2);
        drive(1'b0, 8'hAA, 1'b1);
        check_all("seq_accepted", 3'd2, 1'b0, 1'b0, 1'b0, 8'd2);

        // Left decode, then a stable shoot-through pattern decodes to 7
        drive_n(8'h5A, 1'b1, 4);
        check_all("seq_left", 3'd3, 1'b1, 1'b0, 1'b0, 8'd3);
        drive(1'b0, 8'h0C, 1'b1);
        check_all("seq_shoot_e1", 3'd3, 1'b0, 1'b0, 1'b0, 8'd3);
        drive_n(8'h0C, 1'b1, 3);
        check_all("seq_shoot_code", 3'd7, 1'b1, 1'b1, 1'b0, 8'd4);

        // Event counter wraps 255 -> 0
        drive(1'b1, 8'h00, 1'b1);
        for (int i = 0; i < 256; i++) drive_n((i % 2 == 1) ? 8'hAA : 8'h55, 1'b1, 4);
        check_all("seq_wrap", 3'd2, 1'b1, 1'b0, 1'b0, 8'd0);
        drive_n(8'h55, 1'b1, 4);
        check_all("seq_wrap_plus1", 3'd1, 1'b1, 1'b0, 1'b0, 8'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
